// File: rtl/id_ex_pkg.sv
// id_ex_pkg: shared definitions for the ID/EX pipeline stage
//   - control-word bit positions and width (CTRL_W)
//   - ALU operation encodings
//   - bubble control constant and bubble counter width
package id_ex_pkg;
    localparam int CTRL_W          = 9;
    localparam int CTRL_REG_WRITE  = 8;
    localparam int CTRL_MEM_READ   = 7;
    localparam int CTRL_MEM_WRITE  = 6;
    localparam int CTRL_MEM_TO_REG = 5;
    localparam int CTRL_ALU_SRC    = 4;
    localparam int CTRL_REG_DST    = 3;
    localparam int CTRL_ALU_OP_MSB = 2;
    localparam int CTRL_ALU_OP_LSB = 0;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_AND   = 3'b010,
        ALU_OR    = 3'b011,
        ALU_SLT   = 3'b100,
        ALU_FUNCT = 3'b111
    } alu_op_e;

    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

    localparam int                  BCNT_W   = 16;
    localparam logic [BCNT_W-1:0]   BCNT_MAX = '1;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use hazard detector
// Ports:
//   ex_valid_i, ex_mem_read_i, ex_rt_i : load currently in EX
//   id_valid_i, id_rs_i, id_rt_i       : instruction currently in ID
//   luh_o                              : load-use hazard
module hazard_detect #(
    parameter int RW = 5
) (
    input  logic          ex_valid_i,
    input  logic          ex_mem_read_i,
    input  logic [RW-1:0] ex_rt_i,
    input  logic          id_valid_i,
    input  logic [RW-1:0] id_rs_i,
    input  logic [RW-1:0] id_rt_i,
    output logic          luh_o
);
    // Requiring ex_rt != 0 also keeps r0 sources in ID from ever matching.
    assign luh_o = ex_valid_i && ex_mem_read_i && (ex_rt_i != '0) && id_valid_i &&
                   ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, flush bubbles
// and a saturating bubble counter.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   id_*                  : decoded instruction from ID
//   flush                 : redirect, loads a bubble (highest priority)
//   wb_*                  : register-file write port (used for bypass)
//   ex_*                  : registered EX-side instruction
//   stall                 : hold PC and IF/ID (combinational)
//   bubble_cnt            : saturating count of stall-induced bubbles
// Optional: define ID_EX_WB_BYPASS_EN to forward the write-back value into
// ex_rd1/ex_rd2 when it targets id_rs/id_rt.
module id_ex_stage
    import id_ex_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [DW-1:0]     id_pc,
    input  logic [DW-1:0]     id_rd1,
    input  logic [DW-1:0]     id_rd2,
    input  logic [DW-1:0]     id_imm,
    input  logic [RW-1:0]     id_rs,
    input  logic [RW-1:0]     id_rt,
    input  logic [RW-1:0]     id_rd,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              flush,
    input  logic              wb_reg_write,
    input  logic [RW-1:0]     wb_write_reg,
    input  logic [DW-1:0]     wb_write_data,
    output logic              ex_valid,
    output logic [DW-1:0]     ex_pc,
    output logic [DW-1:0]     ex_rd1,
    output logic [DW-1:0]     ex_rd2,
    output logic [DW-1:0]     ex_imm,
    output logic [RW-1:0]     ex_rs,
    output logic [RW-1:0]     ex_rt,
    output logic [RW-1:0]     ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              stall,
    output logic [BCNT_W-1:0] bubble_cnt
);
    logic              luh;
    logic              bubble;
    logic [DW-1:0]     rd1_src;
    logic [DW-1:0]     rd2_src;
    logic              ex_valid_q, ex_valid_d;
    logic [DW-1:0]     ex_pc_q, ex_pc_d;
    logic [DW-1:0]     ex_rd1_q, ex_rd1_d;
    logic [DW-1:0]     ex_rd2_q, ex_rd2_d;
    logic [DW-1:0]     ex_imm_q, ex_imm_d;
    logic [RW-1:0]     ex_rs_q, ex_rs_d;
    logic [RW-1:0]     ex_rt_q, ex_rt_d;
    logic [RW-1:0]     ex_rd_q, ex_rd_d;
    logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
    logic [BCNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    hazard_detect #(.RW(RW)) u_hazard (
        .ex_valid_i    (ex_valid_q),
        .ex_mem_read_i (ex_ctrl_q[CTRL_MEM_READ]),
        .ex_rt_i       (ex_rt_q),
        .id_valid_i    (id_valid),
        .id_rs_i       (id_rs),
        .id_rt_i       (id_rt),
        .luh_o         (luh)
    );

    assign stall  = luh && !flush;
    assign bubble = luh || flush;

`ifdef ID_EX_WB_BYPASS_EN
    assign rd1_src = (wb_reg_write && wb_write_reg != '0 && wb_write_reg == id_rs) ? wb_write_data : id_rd1;
    assign rd2_src = (wb_reg_write && wb_write_reg != '0 && wb_write_reg == id_rt) ? wb_write_data : id_rd2;
`else
    logic unused_wb;
    assign unused_wb = ^{wb_reg_write, wb_write_reg, wb_write_data};
    assign rd1_src   = id_rd1;
    assign rd2_src   = id_rd2;
`endif

    // A bubble (flush or stall) zeroes everything; an invalid ID slot only
    // zeroes control so it can never write state downstream.
    always_comb begin
        ex_valid_d   = bubble ? 1'b0 : id_valid;
        ex_ctrl_d    = (bubble || !id_valid) ? CTRL_BUBBLE : id_ctrl;
        ex_pc_d      = bubble ? '0 : id_pc;
        ex_rd1_d     = bubble ? '0 : rd1_src;
        ex_rd2_d     = bubble ? '0 : rd2_src;
        ex_imm_d     = bubble ? '0 : id_imm;
        ex_rs_d      = bubble ? '0 : id_rs;
        ex_rt_d      = bubble ? '0 : id_rt;
        ex_rd_d      = bubble ? '0 : id_rd;
        bubble_cnt_d = (stall && bubble_cnt_q != BCNT_MAX) ? bubble_cnt_q + 1'b1 : bubble_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q   <= 1'b0;
            ex_pc_q      <= '0;
            ex_rd1_q     <= '0;
            ex_rd2_q     <= '0;
            ex_imm_q     <= '0;
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_rd_q      <= '0;
            ex_ctrl_q    <= CTRL_BUBBLE;
            bubble_cnt_q <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_pc_q      <= ex_pc_d;
            ex_rd1_q     <= ex_rd1_d;
            ex_rd2_q     <= ex_rd2_d;
            ex_imm_q     <= ex_imm_d;
            ex_rs_q      <= ex_rs_d;
            ex_rt_q      <= ex_rt_d;
            ex_rd_q      <= ex_rd_d;
            ex_ctrl_q    <= ex_ctrl_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ex_pc      = ex_pc_q;
    assign ex_rd1     = ex_rd1_q;
    assign ex_rd2     = ex_rd2_q;
    assign ex_imm     = ex_imm_q;
    assign ex_rs      = ex_rs_q;
    assign ex_rt      = ex_rt_q;
    assign ex_rd      = ex_rd_q;
    assign ex_ctrl    = ex_ctrl_q;
    assign bubble_cnt = bubble_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed bench for id_ex_stage with a cycle-level reference model
module tb_id_ex_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_pc, id_rd1, id_rd2, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [8:0]  id_ctrl;
    logic        flush, wb_reg_write;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;
    logic        ex_valid, stall;
    logic [31:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [8:0]  ex_ctrl;
    logic [15:0] bubble_cnt;

    int checks = 0;
    int failures = 0;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_ctrl(id_ctrl),
        .flush(flush), .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
        .wb_write_data(wb_write_data), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_rs(ex_rs),
        .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .stall(stall),
        .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [31:0] pc, rd1, rd2, imm;
        logic [4:0]  rs, rt, rd;
        logic [8:0]  ctrl;
    } ex_t;

    ex_t         m;
    logic [15:0] m_cnt;
    bit          ovr_en = 1'b0;
    logic [15:0] ovr_val = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // A load in EX (mem_read is ctrl bit 7) whose destination is a nonzero
    // source of the ID instruction.
    function automatic bit m_luh();
        return m.v && m.ctrl[7] && m.rt != 0 && id_valid && (m.rt == id_rs || m.rt == id_rt);
    endfunction

    function automatic logic [31:0] src(input logic [4:0] r, input logic [31:0] d);
`ifdef ID_EX_WB_BYPASS_EN
        if (wb_reg_write && wb_write_reg != 0 && wb_write_reg == r) return wb_write_data;
`endif
        return d;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        int n;
        n = int'(c) + 1;
        return (n > 65535) ? 16'hFFFF : n[15:0];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m     <= '0;
            m_cnt <= '0;
        end else begin
            if (flush || m_luh())
                m <= '0;
            else
                m <= '{v: id_valid, pc: id_pc, rd1: src(id_rs, id_rd1), rd2: src(id_rt, id_rd2),
                       imm: id_imm, rs: id_rs, rt: id_rt, rd: id_rd, ctrl: id_valid ? id_ctrl : 9'h0};
            if (!flush && m_luh())
                m_cnt <= sat_inc(ovr_en ? ovr_val : m_cnt);
            else
                m_cnt <= ovr_en ? ovr_val : m_cnt;
        end
    end

    always @(negedge clk) begin
        chk("ex_valid", ex_valid, m.v);
        chk("ex_pc", ex_pc, m.pc);
        chk("ex_rd1", ex_rd1, m.rd1);
        chk("ex_rd2", ex_rd2, m.rd2);
        chk("ex_imm", ex_imm, m.imm);
        chk("ex_rs", ex_rs, m.rs);
        chk("ex_rt", ex_rt, m.rt);
        chk("ex_rd", ex_rd, m.rd);
        chk("ex_ctrl", ex_ctrl, m.ctrl);
        chk("stall", stall, rst_n ? (m_luh() && !flush) : 1'b0);
        chk("bubble_cnt", bubble_cnt, m_cnt);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [8:0] c,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] im);
        id_valid = v; id_pc = pc; id_ctrl = c; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rd1 = d1; id_rd2 = d2; id_imm = im;
    endtask

    task automatic zero_ex(input string nm);
        chk({nm, "_valid"}, ex_valid, 0);
        chk({nm, "_ctrl"}, ex_ctrl, 0);
        chk({nm, "_data"}, {ex_pc, ex_rd1, ex_rd2, ex_imm} == 0, 1);
        chk({nm, "_regs"}, {ex_rs, ex_rt, ex_rd}, 0);
    endtask

    localparam logic [8:0] LW = 9'h1B0;
    localparam logic [8:0] RT = 9'h100;

    initial begin
        rst_n = 1'b0;
        flush = 0; wb_reg_write = 0; wb_write_reg = 0; wb_write_data = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        zero_ex("rst");
        chk("rst_stall", stall, 0);
        chk("rst_cnt", bubble_cnt, 0);
        rst_n = 1'b1;
        tick();

        drive(1, 32'h40, 9'h1A5, 1, 2, 3, 32'h11, 32'h22, 32'h33);
        #1 chk("norm_stall", stall, 0);
        tick();
        chk("norm_pc", ex_pc, 32'h40);
        chk("norm_ctrl", ex_ctrl, 9'h1A5);
        chk("norm_valid", ex_valid, 1);

        drive(1, 32'h44, LW, 1, 5, 0, 0, 0, 32'h4);
        tick();
        drive(1, 32'h48, RT, 5, 6, 7, 32'hA, 32'hB, 0);
        #1 chk("lu_stall", stall, 1);
        tick();
        chk("lu_bub_valid", ex_valid, 0);
        chk("lu_bub_ctrl", ex_ctrl, 0);
        chk("lu_cnt", bubble_cnt, 1);
        chk("lu_stall_after", stall, 0);
        tick();
        chk("lu_load_pc", ex_pc, 32'h48);
        chk("lu_load_valid", ex_valid, 1);

        drive(1, 32'h4C, LW, 1, 5, 0, 0, 0, 0);
        tick();
        drive(1, 32'h50, RT, 5, 6, 7, 0, 0, 0);
        flush = 1;
        #1 chk("fl_stall", stall, 0);
        tick();
        flush = 0;
        chk("fl_valid", ex_valid, 0);
        chk("fl_cnt", bubble_cnt, 1);

        drive(1, 32'h5C, LW, 1, 0, 0, 0, 0, 0);
        tick();
        drive(1, 32'h60, RT, 0, 0, 3, 0, 0, 0);
        #1 chk("r0_stall", stall, 0);
        tick();
        chk("r0_pc", ex_pc, 32'h60);
        chk("r0_valid", ex_valid, 1);

        drive(0, 32'h64, 9'h1FF, 1, 2, 3, 0, 0, 0);
        tick();
        chk("inv_ctrl", ex_ctrl, 0);
        chk("inv_pc", ex_pc, 32'h64);

        drive(1, 32'h68, RT, 3, 7, 4, 32'h1234, 32'h0, 0);
        wb_reg_write = 1; wb_write_reg = 7; wb_write_data = 32'hDEADBEEF;
        tick();
`ifdef ID_EX_WB_BYPASS_EN
        chk("byp_rd2", ex_rd2, 32'hDEADBEEF);
`else
        chk("byp_rd2", ex_rd2, 32'h0);
`endif
        chk("byp_rd1", ex_rd1, 32'h1234);
        drive(1, 32'h6C, RT, 0, 7, 4, 32'h55, 32'h66, 0);
        wb_write_reg = 0;
        tick();
        chk("byp_r0_rd1", ex_rd1, 32'h55);
        wb_reg_write = 0;

        for (int i = 0; i < 60; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom, {$urandom_range(0, 1) == 1 ? 2'b11 : 2'b10, 7'($urandom)},
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  $urandom, $urandom, $urandom);
            flush = $urandom_range(0, 7) == 0;
            wb_reg_write = 1'($urandom); wb_write_reg = 5'($urandom_range(0, 3)); wb_write_data = $urandom;
            tick();
        end
        flush = 0; wb_reg_write = 0;

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 32'h80, LW, 1, 5, 0, 0, 0, 0);
        tick();
        drive(1, 32'h84, RT, 5, 6, 7, 0, 0, 0);
        @(negedge clk);
        #1;
        force dut.bubble_cnt_q = 16'hFFFF;
        ovr_val = 16'hFFFF; ovr_en = 1'b1;
        #1 release dut.bubble_cnt_q;
        tick();
        ovr_en = 1'b0;
        chk("sat_cnt", bubble_cnt, 16'hFFFF);
        chk("sat_valid", ex_valid, 0);

        tick();
        drive(1, 32'h90, LW, 1, 5, 0, 0, 0, 0);
        tick();
        drive(1, 32'h94, RT, 5, 6, 7, 0, 0, 0);
        #1 chk("mid_stall", stall, 1);
        #1 rst_n = 1'b0;
        #1;
        zero_ex("async_rst");
        chk("async_rst_stall", stall, 0);
        chk("async_rst_cnt", bubble_cnt, 0);
        tick();
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        chk("post_rst_cnt", bubble_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
